// File: rtl/pid_pkg.sv
// ============================================================================
// pid_pkg : shared widths, default timing constants and saturation status
// Revision: 1.0
// ============================================================================
`default_nettype none

package pid_pkg;

   localparam int PID_DATA_W       = 16;
   localparam int PID_PERIOD_DEF   = 1000;
   localparam int PID_DEADTIME_DEF = 4;

   typedef enum logic [1:0] {
      SAT_NONE = 2'd0,
      SAT_HI   = 2'd1,
      SAT_LO   = 2'd2
   } sat_t;

   // Sign-extended sample against a non-negative limit; negative inputs can never alias high.
   function automatic sat_t sat_classify(
      input logic signed [PID_DATA_W:0] sample,
      input logic signed [PID_DATA_W:0] limit
   );
      if (sample[PID_DATA_W]) begin
         return SAT_LO;
      end
      if (sample > limit) begin
         return SAT_HI;
      end
      return SAT_NONE;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pid_deadband.sv
// ============================================================================
// pid_deadband : delays rising edges by DEADTIME cycles, passes falling edges
//                immediately; pulses not longer than DEADTIME are swallowed
// Revision: 1.0
// ============================================================================
`default_nettype none

module pid_deadband
   import pid_pkg::*;
#(
   parameter int DEADTIME = PID_DEADTIME_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic drive_req_next,
   output logic drive
);

   localparam int                 c_len_w   = $clog2(DEADTIME + 2);
   localparam logic [c_len_w-1:0] c_len_max = c_len_w'(DEADTIME + 1);
   localparam logic [c_len_w-1:0] c_len_one = c_len_w'(1);

   logic [c_len_w-1:0] r_len;
   logic [c_len_w-1:0] w_len_next;
   logic               r_drive;

   // Length of the current high streak of the request, saturating once the dead-band has elapsed.
   always_comb begin
      w_len_next = '0;
      if (drive_req_next) begin
         w_len_next = (r_len == c_len_max) ? r_len : r_len + c_len_one;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_len   <= '0;
         r_drive <= 1'b0;
      end else begin
         r_len   <= w_len_next;
         r_drive <= (w_len_next == c_len_max);
      end
   end

   assign drive = r_drive;

endmodule

`default_nettype wire

// File: rtl/pid_pwm_driver.sv
// ============================================================================
// pid_pwm_driver : saturates a signed PID output into a shadow duty that is
//                  applied at period boundaries; optional dead-band with
//                  complementary drive under macro PID_PWM_DEADTIME_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module pid_pwm_driver
   import pid_pkg::*;
#(
   parameter int PERIOD   = PID_PERIOD_DEF,
   parameter int DEADTIME = PID_DEADTIME_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PID_DATA_W-1:0] pid_out,
   input  logic                  in_valid,
   output logic                  pwm,
`ifdef PID_PWM_DEADTIME_EN
   output logic                  pwm_n,
`endif
   output logic                  period_start,
   output logic [PID_DATA_W-1:0] duty,
   output logic                  sat_hi,
   output logic                  sat_lo
);

   localparam logic [PID_DATA_W-1:0]        c_last   = PID_DATA_W'(PERIOD - 1);
   localparam logic [PID_DATA_W-1:0]        c_period = PID_DATA_W'(PERIOD);
   localparam logic signed [PID_DATA_W:0]   c_limit  = (PID_DATA_W + 1)'(PERIOD);

   if (PERIOD < 2 || PERIOD > 65535 || DEADTIME < 0) begin : g_param_err
      $error("pid_pwm_driver: PERIOD must be 2..65535 and DEADTIME non-negative");
   end

   logic                   r_started;
   logic [PID_DATA_W-1:0]  r_cnt;
   logic [PID_DATA_W-1:0]  r_shadow;
   logic [PID_DATA_W-1:0]  r_duty;
   logic                   r_period_start;
   sat_t                   r_sat;

   logic [PID_DATA_W-1:0]  w_cnt_next;
   logic [PID_DATA_W-1:0]  w_duty_next;
   logic                   w_raw_next;
   logic signed [PID_DATA_W:0] w_sample;
   sat_t                   w_sat_class;
   logic [PID_DATA_W-1:0]  w_sat_value;

   // The first edge after reset release only arms the counter, so that cycle shows cnt==0.
   always_comb begin
      w_cnt_next  = r_cnt;
      w_duty_next = r_duty;
      if (r_started) begin
         if (r_cnt == c_last) begin
            w_cnt_next  = '0;
            w_duty_next = r_shadow;
         end else begin
            w_cnt_next = r_cnt + PID_DATA_W'(1);
         end
      end
   end

   // Compare on next-state values so the registered drive lines up with the counter.
   assign w_raw_next = (w_cnt_next < w_duty_next);

   assign w_sample    = {pid_out[PID_DATA_W-1], pid_out};
   assign w_sat_class = sat_classify(w_sample, c_limit);

   always_comb begin
      w_sat_value = pid_out;
      case (w_sat_class)
         SAT_LO:  w_sat_value = '0;
         SAT_HI:  w_sat_value = c_period;
         default: w_sat_value = pid_out;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_started      <= 1'b0;
         r_cnt          <= '0;
         r_shadow       <= '0;
         r_duty         <= '0;
         r_period_start <= 1'b0;
         r_sat          <= SAT_NONE;
      end else begin
         r_started      <= 1'b1;
         r_cnt          <= w_cnt_next;
         r_duty         <= w_duty_next;
         r_period_start <= (w_cnt_next == '0);
         if (in_valid) begin
            r_shadow <= w_sat_value;
            r_sat    <= w_sat_class;
         end
      end
   end

   assign period_start = r_period_start;
   assign duty         = r_duty;
   assign sat_hi       = (r_sat == SAT_HI);
   assign sat_lo       = (r_sat == SAT_LO);

`ifdef PID_PWM_DEADTIME_EN
   logic w_raw_n_next;

   assign w_raw_n_next = ~w_raw_next;

   pid_deadband #(
      .DEADTIME (DEADTIME)
   ) u_deadband_hi (
      .clk            (clk),
      .reset          (reset),
      .drive_req_next (w_raw_next),
      .drive          (pwm)
   );

   pid_deadband #(
      .DEADTIME (DEADTIME)
   ) u_deadband_lo (
      .clk            (clk),
      .reset          (reset),
      .drive_req_next (w_raw_n_next),
      .drive          (pwm_n)
   );
`else
   logic r_raw;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_raw <= 1'b0;
      end else begin
         r_raw <= w_raw_next;
      end
   end

   assign pwm = r_raw;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pid_pwm_driver.sv
// ============================================================================
// tb_pid_pwm_driver : directed checks of pid_pwm_driver with PERIOD=10, DEADTIME=2
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pid_pwm_driver;

   localparam int PERIOD   = 10;
   localparam int DEADTIME = 2;

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] pid_out  = 16'd0;
   logic        pwm;
   logic        period_start;
   logic [15:0] duty;
   logic        sat_hi;
   logic        sat_lo;
`ifdef PID_PWM_DEADTIME_EN
   logic        pwm_n;
`endif

   int total = 0;
   int bad   = 0;
   int m_cnt = 0;

   always #5 clk = ~clk;

   pid_pwm_driver #(
      .PERIOD   (PERIOD),
      .DEADTIME (DEADTIME)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pid_out      (pid_out),
      .in_valid     (in_valid),
      .pwm          (pwm),
`ifdef PID_PWM_DEADTIME_EN
      .pwm_n        (pwm_n),
`endif
      .period_start (period_start),
      .duty         (duty),
      .sat_hi       (sat_hi),
      .sat_lo       (sat_lo)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d (cnt=%0d, t=%0t)", tag, got, exp, m_cnt, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      m_cnt = (m_cnt == PERIOD - 1) ? 0 : m_cnt + 1;
   endtask

   task automatic goto_cnt(input int c);
      for (int i = 0; i < PERIOD && m_cnt != c; i++) tick();
   endtask

   task automatic apply(input logic [15:0] v, input int c);
      goto_cnt(c);
      pid_out  = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic check_period(input int d);
      goto_cnt(0);
      for (int i = 0; i < PERIOD; i++) begin
         check("period_start", period_start, (m_cnt == 0));
         check("duty", duty, d);
`ifndef PID_PWM_DEADTIME_EN
         check("pwm", pwm, (m_cnt < d));
`endif
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_pwm", pwm, 0);
      check("rst_duty", duty, 0);
      check("rst_period_start", period_start, 0);
      check("rst_sat_hi", sat_hi, 0);
      check("rst_sat_lo", sat_lo, 0);

      reset = 1'b1;
      @(negedge clk);
      m_cnt = 0;
      check("first_period_start", period_start, 1);
      check_period(0);
      check_period(0);

      // Mid-period sample must not disturb the running period.
      apply(16'd4, 3);
      while (m_cnt != 0) begin
         check("midperiod_duty", duty, 0);
         check("midperiod_pwm", pwm, 0);
         tick();
      end
      check("sat_after_4", {sat_hi, sat_lo}, 2'b00);
      check_period(4);
      check_period(4);

      // Sample on the last cycle lands one period late.
      apply(16'd6, 9);
      check_period(4);
      check_period(6);

      apply(16'd3, 2);
      apply(16'd8, 5);
      check_period(8);

      apply(16'hFFFB, 3);
      check("sat_lo_neg5", sat_lo, 1);
      check("sat_hi_neg5", sat_hi, 0);
      check_period(0);
      check_period(0);

      apply(16'd200, 3);
      check("sat_hi_200", sat_hi, 1);
      check("sat_lo_200", sat_lo, 0);
      check_period(10);
      check_period(10);

      apply(16'd10, 3);
      check("sat_eq_period", {sat_hi, sat_lo}, 2'b00);
      check_period(10);

      apply(16'd11, 3);
      check("sat_hi_11", {sat_hi, sat_lo}, 2'b10);
      check_period(10);

      apply(16'h8000, 3);
      check("sat_lo_min", {sat_hi, sat_lo}, 2'b01);
      check_period(0);

      apply(16'h7FFF, 3);
      check("sat_hi_max", {sat_hi, sat_lo}, 2'b10);
      check_period(10);

      apply(16'd0, 3);
      check("sat_zero", {sat_hi, sat_lo}, 2'b00);
      check_period(0);

      // Asynchronous reset in the middle of a period with duty 7 and sat_hi set.
      apply(16'd7, 3);
      check_period(7);
      apply(16'd200, 2);
      goto_cnt(5);
      check("pre_rst_duty", duty, 7);
      check("pre_rst_sat_hi", sat_hi, 1);
`ifndef PID_PWM_DEADTIME_EN
      check("pre_rst_pwm", pwm, 1);
`endif
      reset = 1'b0;
      #1;
      check("async_pwm", pwm, 0);
      check("async_duty", duty, 0);
      check("async_period_start", period_start, 0);
      check("async_sat_hi", sat_hi, 0);
      check("async_sat_lo", sat_lo, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      m_cnt = 0;
      check("rel_period_start", period_start, 1);
      check("rel_duty", duty, 0);
      check("rel_pwm", pwm, 0);
      check_period(0);

`ifdef PID_PWM_DEADTIME_EN
      apply(16'd5, 3);
      goto_cnt(0);
      for (int i = 0; i < PERIOD; i++) begin
         check("db5_pwm", pwm, (m_cnt >= DEADTIME && m_cnt < 5));
         check("db5_pwm_n", pwm_n, (m_cnt >= 5 + DEADTIME));
         check("db5_overlap", pwm & pwm_n, 0);
         tick();
      end
      apply(16'd1, 3);
      goto_cnt(0);
      for (int i = 0; i < PERIOD; i++) begin
         check("db1_pwm", pwm, 0);
         check("db1_overlap", pwm & pwm_n, 0);
         tick();
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
